pcileech_tlp_tx_arbiter: RTL and testbench

// Shares the single 64-bit PCIe core transmit stream (tlp_tx) between NUM_SRC TLP sources.

---
 rtl/pcileech_tlp_tx_arbiter_if.sv | 29 ++
 rtl/pcileech_tlp_tx_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_pcileech_tlp_tx_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcileech_tlp_tx_arbiter_if.sv
// Bundle of per-source TLP beat channels plus the shared 64-bit tlp_tx stream.
// master = arbiter side, slave = sources/core side.
interface pcileech_tlp_tx_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0]    src_en;
  logic [NUM_SRC-1:0]    src_has_data;
  logic [NUM_SRC-1:0]    src_gnt;
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC-1:0]    src_ready;
  logic [NUM_SRC*64-1:0] src_data;
  logic [NUM_SRC*8-1:0]  src_keep;
  logic [NUM_SRC-1:0]    src_last;
  logic [63:0]           tlp_tx_data;
  logic [7:0]            tlp_tx_keep;
  logic                  tlp_tx_last;
  logic                  tlp_tx_valid;
  logic                  tlp_tx_ready;

  modport master (
    input  src_en, src_has_data, src_valid, src_data, src_keep, src_last, tlp_tx_ready,
    output src_gnt, src_ready, tlp_tx_data, tlp_tx_keep, tlp_tx_last, tlp_tx_valid
  );

  modport slave (
    output src_en, src_has_data, src_valid, src_data, src_keep, src_last, tlp_tx_ready,
    input  src_gnt, src_ready, tlp_tx_data, tlp_tx_keep, tlp_tx_last, tlp_tx_valid
  );
endinterface

// File: rtl/pcileech_tlp_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the PCIe core tlp_tx stream between NUM_SRC sources,
// with optional source-0 priority, starvation guard and grant-to-first-beat timeout.
module pcileech_tlp_tx_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int HIPRI_SRC0   = 1,
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT_CYC  = 64,
  parameter int MAX_BEATS    = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  pcileech_tlp_tx_arbiter_if.master bus,
  output logic [2:0]                gnt_id_o,
  output logic                      busy_o,
  output logic [15:0]               timeout_cnt_o,
  output logic [15:0]               overlong_cnt_o
);

  // state | meaning
  // IDLE  | no grant outstanding; winner granted on any eligible source
  // WAIT  | granted, waiting for first beat; times out after TIMEOUT_CYC cycles
  // XFER  | forwarding the granted TLP until its last beat
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, XFER = 2'd2} state_t;

  localparam int IW = $clog2(NUM_SRC);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SRC - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      beats_q, beats_d;
  logic [15:0]     tmo_q, tmo_d;
  logic [15:0]     ovl_q, ovl_d;
  logic            txv_q, txv_d;
  logic [63:0]     txd_q, txd_d;
  logic [7:0]      txk_q, txk_d;
  logic            txl_q, txl_d;

  logic [NUM_SRC-1:0] elig;
  logic               others_elig, any_elig, starved;
  logic               rr_found, nz_found;
  logic [IW-1:0]      rr_w, nz_w, win, j;

  // Winner search: rr_w over all sources, nz_w skips source 0 for the starvation case.
  always_comb begin
    elig        = bus.src_en & bus.src_has_data;
    others_elig = |elig[NUM_SRC-1:1];
    any_elig    = |elig;
    rr_w        = '0;
    nz_w        = '0;
    rr_found    = 1'b0;
    nz_found    = 1'b0;
    j           = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = IW'((int'(rr_q) + k) % NUM_SRC);
      if (!rr_found && elig[j]) begin
        rr_found = 1'b1;
        rr_w     = j;
      end
      if (!nz_found && (j != '0) && elig[j]) begin
        nz_found = 1'b1;
        nz_w     = j;
      end
    end
    starved = (streak_q >= SW'(STARVE_LIMIT)) && others_elig;
    if ((HIPRI_SRC0 != 0) && elig[0]) win = starved ? nz_w : '0;
    else                              win = rr_w;
  end

  logic [63:0] sel_data;
  logic [7:0]  sel_keep;
  logic        sel_valid, sel_last, rdy, accept;

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (idx_q == IW'(i)) begin
        sel_data  = bus.src_data[i*64 +: 64];
        sel_keep  = bus.src_keep[i*8 +: 8];
        sel_valid = bus.src_valid[i];
        sel_last  = bus.src_last[i];
      end
    end
    rdy    = (state_q != IDLE) && (!txv_q || bus.tlp_tx_ready) && !rst;
    accept = rdy && sel_valid;
  end

  always_comb begin
    bus.src_gnt   = '0;
    bus.src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.src_ready[i] = rdy && (idx_q == IW'(i));
      bus.src_gnt[i]   = (state_q == IDLE) && any_elig && !rst && (win == IW'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_d     = rr_q;
    streak_d = streak_q;
    timer_d  = timer_q;
    beats_d  = beats_q;
    tmo_d    = tmo_q;
    ovl_d    = ovl_q;
    txv_d    = txv_q;
    txd_d    = txd_q;
    txk_d    = txk_q;
    txl_d    = txl_q;

    if (accept) begin
      txv_d = 1'b1;
      txd_d = sel_data;
      txk_d = sel_keep;
      txl_d = sel_last;
      if (beats_q != 8'hFF) beats_d = beats_q + 8'd1;
      // Fires only on the transition to beat MAX_BEATS+1, so once per TLP.
      if ((beats_q == 8'(MAX_BEATS)) && (ovl_q != 16'hFFFF)) ovl_d = ovl_q + 16'd1;
    end else if (bus.tlp_tx_ready) begin
      txv_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d = WAIT;
          idx_d   = win;
          rr_d    = (win == LAST_IDX) ? '0 : win + 1'b1;
          timer_d = TW'(TIMEOUT_CYC - 1);
          beats_d = '0;
          if (win == '0) begin
            if (others_elig && (streak_q != SW'(STARVE_LIMIT))) streak_d = streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
        end
      end
      WAIT: begin
        if (accept) begin
          state_d = sel_last ? IDLE : XFER;
        end else if (timer_q == '0) begin
          state_d = IDLE;
          if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      XFER: begin
        if (accept && sel_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rr_q     <= '0;
      streak_q <= '0;
      timer_q  <= '0;
      beats_q  <= '0;
      tmo_q    <= '0;
      ovl_q    <= '0;
      txv_q    <= 1'b0;
      txd_q    <= '0;
      txk_q    <= '0;
      txl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      streak_q <= streak_d;
      timer_q  <= timer_d;
      beats_q  <= beats_d;
      tmo_q    <= tmo_d;
      ovl_q    <= ovl_d;
      txv_q    <= txv_d;
      txd_q    <= txd_d;
      txk_q    <= txk_d;
      txl_q    <= txl_d;
    end
  end

  assign bus.tlp_tx_valid = txv_q;
  assign bus.tlp_tx_data  = txd_q;
  assign bus.tlp_tx_keep  = txk_q;
  assign bus.tlp_tx_last  = txl_q;
  assign gnt_id_o         = 3'(idx_q);
  assign busy_o           = (state_q != IDLE);
  assign timeout_cnt_o    = tmo_q;
  assign overlong_cnt_o   = ovl_q;

endmodule

// File: tb/tb_pcileech_tlp_tx_arbiter.sv
// Bench for pcileech_tlp_tx_arbiter: source models with TLP queues, a transaction-level
// arbitration/scoreboard model, directed phases followed by a randomized phase.
module tb_pcileech_tlp_tx_arbiter;
  localparam int N    = 4;
  localparam int TMO  = 64;
  localparam int MAXB = 18;
  localparam int SL   = 8;

  logic        clk;
  logic        rst;
  logic [2:0]  gnt_id;
  logic        busy;
  logic [15:0] timeout_cnt;
  logic [15:0] overlong_cnt;

  pcileech_tlp_tx_arbiter_if #(.NUM_SRC(N)) bus ();

  pcileech_tlp_tx_arbiter #(
    .NUM_SRC(N), .HIPRI_SRC0(1), .STARVE_LIMIT(SL), .TIMEOUT_CYC(TMO), .MAX_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .gnt_id_o(gnt_id), .busy_o(busy), .timeout_cnt_o(timeout_cnt), .overlong_cnt_o(overlong_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // source models
  int q_len [N][64];
  int head [N];
  int tail [N];
  int seq [N];
  int beat [N];
  bit active [N];
  bit mute [N];
  bit [N-1:0] en;
  int rdy_mode;
  int pat_idx;
  bit vgap;
  bit ren;

  // transaction-level reference
  bit m_busy, m_started, m_txv;
  int m_src, m_rr, m_streak, m_wait, m_beats, m_tmo, m_ovl, m_gid;
  logic [72:0] exp_q [$];
  int gnt_log [$];
  int gnt_cyc [$];
  int cyc, tx_seen, acc_total;
  logic [72:0] prev_tx;
  bit prev_hold;

  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int s, input int len);
    q_len[s][tail[s]] = len;
    tail[s]++;
  endtask

  task automatic model_init();
    m_busy = 0; m_started = 0; m_txv = 0;
    m_src = 0; m_rr = 0; m_streak = 0; m_wait = 0; m_beats = 0; m_tmo = 0; m_ovl = 0; m_gid = 0;
    exp_q.delete(); gnt_log.delete(); gnt_cyc.delete();
    tx_seen = 0; acc_total = 0; prev_hold = 0; prev_tx = '0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0; tail[i] = 0; seq[i] = 0; beat[i] = 0; active[i] = 0; mute[i] = 0;
    end
    en = '0; rdy_mode = 0; pat_idx = 0; vgap = 0; ren = 0;
  endtask

  task automatic drive();
    bit lst;
    if (ren) en = N'($urandom_range(0, (1 << N) - 1));
    for (int i = 0; i < N; i++) begin
      lst = active[i] && (beat[i] == q_len[i][head[i]] - 1);
      bus.src_en[i]       = en[i];
      bus.src_has_data[i] = (head[i] < tail[i]);
      bus.src_valid[i]    = active[i] && !mute[i] && (!vgap || ($urandom_range(0, 3) != 0));
      bus.src_last[i]     = lst;
      bus.src_keep[i*8 +: 8] = lst ? 8'h0F : 8'hFF;
      if (active[i]) bus.src_data[i*64 +: 64] = {8'(i), 24'(seq[i]), 32'(beat[i])};
      else           bus.src_data[i*64 +: 64] = {$urandom, $urandom};
    end
    case (rdy_mode)
      1: begin
        bus.tlp_tx_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
        pat_idx++;
      end
      2:       bus.tlp_tx_ready = ($urandom_range(0, 3) != 0);
      default: bus.tlp_tx_ready = 1'b1;
    endcase
  endtask

  function automatic int pick(input bit [N-1:0] e);
    int jj;
    if (e[0] && m_streak >= SL && (e[N-1:1] != '0)) begin
      for (int k = 0; k < N; k++) begin
        jj = (m_rr + k) % N;
        if (jj != 0 && e[jj]) return jj;
      end
    end
    if (e[0]) return 0;
    for (int k = 0; k < N; k++) begin
      jj = (m_rr + k) % N;
      if (e[jj]) return jj;
    end
    return -1;
  endfunction

  task automatic cycle();
    bit [N-1:0] elig, exp_gnt, exp_rdy;
    int w;
    bit acc;
    logic [72:0] cur, e;
    drive();
    #4;
    for (int i = 0; i < N; i++) elig[i] = en[i] && (head[i] < tail[i]);
    exp_gnt = '0;
    exp_rdy = '0;
    w = -1;
    if (!m_busy && elig != '0) begin
      w = pick(elig);
      exp_gnt[w] = 1'b1;
    end
    if (m_busy && (!m_txv || bus.tlp_tx_ready)) exp_rdy[m_src] = 1'b1;
    cur = {bus.tlp_tx_data, bus.tlp_tx_keep, bus.tlp_tx_last};
    chk("gnt", bus.src_gnt, exp_gnt);
    chk("ready", bus.src_ready, exp_rdy);
    chk("tx_valid", bus.tlp_tx_valid, m_txv);
    chk("busy", busy, m_busy);
    chk("gnt_id", gnt_id, m_gid);
    chk("timeout_cnt", timeout_cnt, m_tmo);
    chk("overlong_cnt", overlong_cnt, m_ovl);
    if (prev_hold) chk("tx_hold", cur, prev_tx);
    if (bus.src_gnt != '0) begin
      for (int i = 0; i < N; i++) if (bus.src_gnt[i]) gnt_log.push_back(i);
      gnt_cyc.push_back(cyc);
    end
    if (bus.tlp_tx_valid && bus.tlp_tx_ready) begin
      tx_seen++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      chk("tx_beat", cur, e);
    end
    prev_hold = bus.tlp_tx_valid && !bus.tlp_tx_ready;
    prev_tx = cur;

    acc = m_busy && exp_rdy[m_src] && bus.src_valid[m_src];
    m_txv = acc ? 1'b1 : (bus.tlp_tx_ready ? 1'b0 : m_txv);
    if (w >= 0) begin
      if (w == 0) begin
        if (elig[N-1:1] != '0) m_streak++;
      end else m_streak = 0;
      m_busy = 1; m_src = w; m_gid = w; m_rr = (w + 1) % N;
      m_wait = 0; m_started = 0; m_beats = 0;
      active[w] = 1; beat[w] = 0;
    end else if (m_busy) begin
      if (acc) begin
        exp_q.push_back({bus.src_data[m_src*64 +: 64], bus.src_keep[m_src*8 +: 8], bus.src_last[m_src]});
        acc_total++;
        m_started = 1;
        m_beats++;
        if (m_beats == MAXB + 1) m_ovl++;
        beat[m_src]++;
        if (bus.src_last[m_src]) begin
          m_busy = 0; active[m_src] = 0; head[m_src]++; seq[m_src]++;
        end
      end else if (!m_started) begin
        m_wait++;
        if (m_wait == TMO) begin
          m_busy = 0; m_tmo++; active[m_src] = 0;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) return 0;
    return !m_busy && !m_txv && (exp_q.size() == 0);
  endfunction

  task automatic run(input int max);
    int n = 0;
    while (!drained() && n < max) begin
      cycle();
      n++;
    end
    chk("drain_bound", drained(), 1'b1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, bus.src_gnt, '0);
    chk({tag, "_ready"}, bus.src_ready, '0);
    chk({tag, "_txv"}, bus.tlp_tx_valid, '0);
    chk({tag, "_txd"}, {bus.tlp_tx_data, bus.tlp_tx_keep, bus.tlp_tx_last}, '0);
    chk({tag, "_gnt_id"}, gnt_id, '0);
    chk({tag, "_busy"}, busy, '0);
    chk({tag, "_cnts"}, {timeout_cnt, overlong_cnt}, '0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    model_init();
    drive();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_zero("reset");
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int novl;
    int n;
    rst = 1'b1;
    cyc = 0;
    model_init();

    // single source, 3 beats
    reset_dut();
    en = 4'b0010;
    push(1, 3);
    run(50);
    chk("single_ngnt", gnt_log.size(), 1);
    chk("single_gnt", gnt_log[0], 1);
    chk("single_beats", tx_seen, 3);

    // round robin among 1..3
    reset_dut();
    en = 4'b1110;
    for (int t = 0; t < 4; t++) begin push(1, 1); push(2, 1); push(3, 1); end
    run(200);
    for (int k = 0; k < 6; k++) chk("rr_order", gnt_log[k], k % 3 + 1);

    // source-0 priority with starvation guard
    reset_dut();
    en = 4'b0101;
    for (int t = 0; t < 18; t++) push(0, 1);
    for (int t = 0; t < 3; t++) push(2, 1);
    run(300);
    for (int k = 0; k < 18; k++) chk("prio_order", gnt_log[k], (k % 9 == 8) ? 2 : 0);

    // backpressure 1,0,0,1
    reset_dut();
    en = 4'b0100;
    rdy_mode = 1;
    push(2, 4);
    run(100);
    chk("bp_beats", tx_seen, 4);

    // grant timeout on silent source 3
    reset_dut();
    en = 4'b1010;
    mute[3] = 1;
    push(3, 2);
    cycle();
    en[3] = 1'b0;
    head[3] = tail[3];
    push(1, 2);
    run(300);
    chk("tmo_gnt0", gnt_log[0], 3);
    chk("tmo_gnt1", gnt_log[1], 1);
    chk("tmo_gap", gnt_cyc[1] - gnt_cyc[0], TMO + 1);
    chk("tmo_cnt", timeout_cnt, 1);
    chk("tmo_beats", tx_seen, 2);

    // overlong boundary: 18 fits, 19 and 20 flagged
    reset_dut();
    en = 4'b0001;
    push(0, 18); push(0, 19); push(0, 20);
    run(300);
    chk("ovl_cnt", overlong_cnt, 2);
    chk("ovl_beats", tx_seen, 57);

    // reset in the middle of a TLP
    reset_dut();
    en = 4'b0010;
    push(1, 8);
    n = 0;
    while (acc_total < 5 && n < 50) begin cycle(); n++; end
    chk("midrst_reach", acc_total, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("midrst");

    // randomized traffic
    reset_dut();
    vgap = 1; rdy_mode = 2; ren = 1;
    novl = 0;
    for (int i = 0; i < N; i++) begin
      for (int t = 0; t < 6; t++) begin
        n = $urandom_range(1, 24);
        push(i, n);
        if (n > MAXB) novl++;
      end
    end
    run(5000);
    chk("rand_ovl", overlong_cnt, novl);
    chk("rand_tmo", timeout_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
